// File: rtl/exu_trap.sv
// exu_trap: trap-entry / mret sequencer for the execute stage.
// Accepts one trap or mret request at a time and performs the machine-mode
// CSR writes over a single stallable write port. It then flushes and redirects
// fetch to the trap vector or to mepc.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | ready for a request, no flush
// S_W_MEPC    | trap only: write latched PC to mepc
// S_W_MCAUSE  | trap only: write latched cause to mcause
// S_W_MSTATUS | write updated mstatus (trap entry or mret restore)
// S_REDIR     | present redirect target until fetch takes it
module exu_trap (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_trap_vld,
  input  logic [31:0] i_mcause,
  input  logic [31:0] i_pc,
  input  logic        i_mret,
  output logic        o_trap_rdy,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  input  logic        i_mstatus_mie,
  input  logic        i_mstatus_mpie,
  output logic        o_csr_we,
  output logic [11:0] o_csr_waddr,
  output logic [31:0] o_csr_wdata,
  input  logic        i_csr_wrdy,
  output logic        o_flush,
  output logic        o_redirect_vld,
  output logic [31:0] o_redirect_pc,
  input  logic        i_redirect_rdy,
  output logic        o_busy
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MSTATUS,
    S_REDIR
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cause;
  logic [31:0] r_pc;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic        r_mie;
  logic        r_mpie;
  logic        r_is_mret;

  logic        w_idle;
  logic        w_accept;
  logic [31:0] w_base;
  logic [31:0] w_vec_pc;
  logic [31:0] w_trap_pc;
  logic [31:0] w_mstatus;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && (i_trap_vld || i_mret);

  // State register and request latch; a trap wins over a simultaneous mret.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cause   <= '0;
      r_pc      <= '0;
      r_mtvec   <= '0;
      r_mepc    <= '0;
      r_mie     <= 1'b0;
      r_mpie    <= 1'b0;
      r_is_mret <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cause   <= i_mcause;
        r_pc      <= i_pc & 32'hFFFF_FFFE;
        r_mtvec   <= i_mtvec;
        r_mepc    <= i_mepc & 32'hFFFF_FFFE;
        r_mie     <= i_mstatus_mie;
        r_mpie    <= i_mstatus_mpie;
        r_is_mret <= ~i_trap_vld;
      end
    end
  end

  // Next-state sequencing; each W_* state stalls until the CSR file takes the write.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_trap_vld)  w_state_nxt = S_W_MEPC;
        else if (i_mret) w_state_nxt = S_W_MSTATUS;
      end
      S_W_MEPC:    if (i_csr_wrdy)     w_state_nxt = S_W_MCAUSE;
      S_W_MCAUSE:  if (i_csr_wrdy)     w_state_nxt = S_W_MSTATUS;
      S_W_MSTATUS: if (i_csr_wrdy)     w_state_nxt = S_REDIR;
      S_REDIR:     if (i_redirect_rdy) w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // Vectored mode only applies to interrupts; reserved modes fall back to base.
  assign w_base    = {r_mtvec[31:2], 2'b00};
  assign w_vec_pc  = w_base + {r_cause[29:0], 2'b00};
  assign w_trap_pc = ((r_mtvec[1:0] == 2'b01) && r_cause[31]) ? w_vec_pc : w_base;
  assign w_mstatus = r_is_mret ? {19'd0, 2'b11, 3'd0, 1'b1,  3'd0, r_mpie, 3'd0}
                               : {19'd0, 2'b11, 3'd0, r_mie, 3'd0, 1'b0,   3'd0};

  // Output decode from registered state and latched data only.
  always_comb begin
    o_csr_we       = 1'b0;
    o_csr_waddr    = '0;
    o_csr_wdata    = '0;
    o_redirect_vld = 1'b0;
    o_redirect_pc  = '0;
    case (r_state)
      S_W_MEPC: begin
        o_csr_we    = 1'b1;
        o_csr_waddr = ADDR_MEPC;
        o_csr_wdata = r_pc;
      end
      S_W_MCAUSE: begin
        o_csr_we    = 1'b1;
        o_csr_waddr = ADDR_MCAUSE;
        o_csr_wdata = r_cause;
      end
      S_W_MSTATUS: begin
        o_csr_we    = 1'b1;
        o_csr_waddr = ADDR_MSTATUS;
        o_csr_wdata = w_mstatus;
      end
      S_REDIR: begin
        o_redirect_vld = 1'b1;
        o_redirect_pc  = r_is_mret ? r_mepc : w_trap_pc;
      end
      default: ;
    endcase
  end

  assign o_trap_rdy = w_idle;
  assign o_busy     = ~w_idle;
  assign o_flush    = ~w_idle;

endmodule

// File: tb/tb_exu_trap.sv
// Testbench for exu_trap: directed trap/mret vectors with hand-computed CSR
// writes and redirect targets, checked by a scoreboard monitor.
module tb_exu_trap;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_trap_vld, i_mret;
  logic [31:0] i_mcause, i_pc, i_mtvec, i_mepc;
  logic        i_mstatus_mie, i_mstatus_mpie;
  logic        o_trap_rdy;
  logic        o_csr_we;
  logic [11:0] o_csr_waddr;
  logic [31:0] o_csr_wdata;
  logic        i_csr_wrdy;
  logic        o_flush;
  logic        o_redirect_vld;
  logic [31:0] o_redirect_pc;
  logic        i_redirect_rdy;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_redir;
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  exu_trap dut (
    .clk(clk), .rst_n(rst_n),
    .i_trap_vld(i_trap_vld), .i_mcause(i_mcause), .i_pc(i_pc), .i_mret(i_mret),
    .o_trap_rdy(o_trap_rdy), .i_mtvec(i_mtvec), .i_mepc(i_mepc),
    .i_mstatus_mie(i_mstatus_mie), .i_mstatus_mpie(i_mstatus_mpie),
    .o_csr_we(o_csr_we), .o_csr_waddr(o_csr_waddr), .o_csr_wdata(o_csr_wdata),
    .i_csr_wrdy(i_csr_wrdy), .o_flush(o_flush), .o_redirect_vld(o_redirect_vld),
    .o_redirect_pc(o_redirect_pc), .i_redirect_rdy(i_redirect_rdy), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic push_csr(input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    e.is_redir = 1'b0; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_redir(input logic [31:0] pc);
    exp_t e;
    e.is_redir = 1'b1; e.addr = '0; e.data = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: handshakes and hold-stability are sampled on the falling edge.
  logic        prev_whold = 1'b0, prev_rhold = 1'b0;
  logic [11:0] prev_addr;
  logic [31:0] prev_wdata, prev_rpc;
  always @(negedge clk) begin
    exp_t e;
    if (prev_whold) begin
      checks++;
      if (!o_csr_we || o_csr_waddr !== prev_addr || o_csr_wdata !== prev_wdata) begin
        errors++;
        $display("FAIL csr_hold: we=%0b addr=0x%03h data=0x%08h, expected addr=0x%03h data=0x%08h",
                 o_csr_we, o_csr_waddr, o_csr_wdata, prev_addr, prev_wdata);
      end
    end
    if (prev_rhold) begin
      checks++;
      if (!o_redirect_vld || o_redirect_pc !== prev_rpc) begin
        errors++;
        $display("FAIL redir_hold: vld=%0b pc=0x%08h, expected pc=0x%08h",
                 o_redirect_vld, o_redirect_pc, prev_rpc);
      end
    end
    if (rst_n && o_csr_we && i_csr_wrdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL csr_unexpected: addr=0x%03h data=0x%08h, expected no write", o_csr_waddr, o_csr_wdata);
      end else begin
        e = exp_q.pop_front();
        if (e.is_redir || o_csr_waddr !== e.addr || o_csr_wdata !== e.data) begin
          errors++;
          $display("FAIL csr_write: addr=0x%03h data=0x%08h, expected redir=%0b addr=0x%03h data=0x%08h",
                   o_csr_waddr, o_csr_wdata, e.is_redir, e.addr, e.data);
        end
      end
    end
    if (rst_n && o_redirect_vld && i_redirect_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL redir_unexpected: pc=0x%08h, expected no redirect", o_redirect_pc);
      end else begin
        e = exp_q.pop_front();
        if (!e.is_redir || o_redirect_pc !== e.data) begin
          errors++;
          $display("FAIL redirect: pc=0x%08h, expected redir=%0b value=0x%08h",
                   o_redirect_pc, e.is_redir, e.data);
        end
      end
    end
    prev_whold = rst_n && o_csr_we && !i_csr_wrdy;
    prev_rhold = rst_n && o_redirect_vld && !i_redirect_rdy;
    prev_addr  = o_csr_waddr;
    prev_wdata = o_csr_wdata;
    prev_rpc   = o_redirect_pc;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic trap, input logic mret, input logic [31:0] cause,
                       input logic [31:0] pc, input logic [31:0] mtvec, input logic [31:0] mepc,
                       input logic mie, input logic mpie);
    i_trap_vld = trap; i_mret = mret; i_mcause = cause; i_pc = pc;
    i_mtvec = mtvec; i_mepc = mepc; i_mstatus_mie = mie; i_mstatus_mpie = mpie;
  endtask

  // Called right after the accepting edge (start of cycle 1). Drives ready
  // masks per cycle and measures the redirect and ready-again cycles.
  task automatic wait_idle(input string name, input bit clr, input logic [31:0] wlow,
                           input logic [31:0] rlow, input int exp_redir, input int exp_rdy);
    int n = 1;
    int redir_at = 0;
    bit flush_bad = 0;
    if (clr) begin i_trap_vld = 1'b0; i_mret = 1'b0; end
    while (n < 31) begin
      i_csr_wrdy     = ~wlow[n];
      i_redirect_rdy = ~rlow[n];
      if (o_redirect_vld && redir_at == 0) redir_at = n;
      if (o_flush !== ~o_trap_rdy || o_busy !== ~o_trap_rdy) flush_bad = 1;
      if (o_trap_rdy) break;
      tick;
      n++;
    end
    i_csr_wrdy = 1'b1; i_redirect_rdy = 1'b1;
    check({name, "_redir_cycle"}, redir_at, exp_redir);
    check({name, "_rdy_cycle"}, n, exp_rdy);
    check({name, "_flush_busy"}, {31'd0, flush_bad}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_we"},    {31'd0, o_csr_we}, 32'd0);
    check({name, "_waddr"}, {20'd0, o_csr_waddr}, 32'd0);
    check({name, "_wdata"}, o_csr_wdata, 32'd0);
    check({name, "_flush"}, {31'd0, o_flush}, 32'd0);
    check({name, "_rvld"},  {31'd0, o_redirect_vld}, 32'd0);
    check({name, "_rpc"},   o_redirect_pc, 32'd0);
    check({name, "_busy"},  {31'd0, o_busy}, 32'd0);
    check({name, "_rdy"},   {31'd0, o_trap_rdy}, 32'd1);
  endtask

  task automatic check_drained(input string name);
    check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    i_csr_wrdy = 1'b1; i_redirect_rdy = 1'b1;
    tick; tick;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick;

    // Illegal-instruction trap
    push_csr(12'h341, 32'h8000_0102); push_csr(12'h342, 32'h0000_0002);
    push_csr(12'h300, 32'h0000_1880); push_redir(32'h8000_0000);
    issue(1, 0, 32'h2, 32'h8000_0102, 32'h8000_0000, 32'h1234_5678, 1, 0);
    tick;
    wait_idle("illegal", 1, 0, 0, 4, 5);
    check_drained("illegal");

    // Vectored interrupt, odd PC bit cleared, MIE=0
    push_csr(12'h341, 32'h8000_0010); push_csr(12'h342, 32'h8000_0007);
    push_csr(12'h300, 32'h0000_1800); push_redir(32'h8000_001C);
    issue(1, 0, 32'h8000_0007, 32'h8000_0011, 32'h8000_0001, 0, 0, 1);
    tick;
    wait_idle("vectored", 1, 0, 0, 4, 5);
    check_drained("vectored");

    // Vectored wrap-around
    push_csr(12'h341, 32'h0000_0040); push_csr(12'h342, 32'h8000_0007);
    push_csr(12'h300, 32'h0000_1880); push_redir(32'h0000_000C);
    issue(1, 0, 32'h8000_0007, 32'h0000_0040, 32'hFFFF_FFF1, 0, 1, 1);
    tick;
    wait_idle("wrap", 1, 0, 0, 4, 5);
    check_drained("wrap");

    // Reserved mode 2'b10 with interrupt cause -> base
    push_csr(12'h341, 32'h0000_1000); push_csr(12'h342, 32'h8000_0003);
    push_csr(12'h300, 32'h0000_1800); push_redir(32'h8000_0100);
    issue(1, 0, 32'h8000_0003, 32'h0000_1000, 32'h8000_0102, 0, 0, 0);
    tick;
    wait_idle("reserved", 1, 0, 0, 4, 5);
    check_drained("reserved");

    // Vectored mode with an exception cause -> base
    push_csr(12'h341, 32'h0000_2000); push_csr(12'h342, 32'h0000_0005);
    push_csr(12'h300, 32'h0000_1800); push_redir(32'h8000_0200);
    issue(1, 0, 32'h0000_0005, 32'h0000_2000, 32'h8000_0201, 0, 0, 0);
    tick;
    wait_idle("vec_exc", 1, 0, 0, 4, 5);
    check_drained("vec_exc");

    // mret with MPIE=1
    push_csr(12'h300, 32'h0000_1888); push_redir(32'h8000_0204);
    issue(0, 1, 32'hDEAD_BEEF, 32'h4, 32'h8000_0000, 32'h8000_0205, 0, 1);
    tick;
    wait_idle("mret1", 1, 0, 0, 2, 3);
    check_drained("mret1");

    // mret with MPIE=0, MIE=1
    push_csr(12'h300, 32'h0000_1880); push_redir(32'h0000_0300);
    issue(0, 1, 0, 0, 0, 32'h0000_0300, 1, 0);
    tick;
    wait_idle("mret0", 1, 0, 0, 2, 3);
    check_drained("mret0");

    // Backpressure: wrdy low cycles 2-4 (W_MCAUSE), redirect_rdy low cycles 7-8
    push_csr(12'h341, 32'h0000_0500); push_csr(12'h342, 32'h0000_000B);
    push_csr(12'h300, 32'h0000_1880); push_redir(32'h8000_0000);
    issue(1, 0, 32'hB, 32'h0000_0500, 32'h8000_0000, 0, 1, 0);
    tick;
    wait_idle("bp", 1, 32'b1_1100, 32'b1_1000_0000, 7, 10);
    check_drained("bp");

    // Simultaneous trap+mret, then a second trap held while busy
    push_csr(12'h341, 32'h0000_0600); push_csr(12'h342, 32'h0000_0004);
    push_csr(12'h300, 32'h0000_1800); push_redir(32'h8000_0000);
    push_csr(12'h341, 32'h0000_0700); push_csr(12'h342, 32'h0000_0006);
    push_csr(12'h300, 32'h0000_1880); push_redir(32'h9000_0000);
    issue(1, 1, 32'h4, 32'h0000_0600, 32'h8000_0000, 32'h0000_0AA0, 0, 1);
    tick;
    issue(1, 0, 32'h6, 32'h0000_0700, 32'h9000_0000, 0, 1, 0);
    wait_idle("both", 0, 0, 0, 4, 5);
    tick;
    wait_idle("second", 1, 0, 0, 4, 5);
    check_drained("both");

    // Reset while in W_MCAUSE: only the mepc write may happen
    push_csr(12'h341, 32'h0000_0800);
    issue(1, 0, 32'h2, 32'h0000_0800, 32'h8000_0000, 0, 1, 0);
    tick;
    i_trap_vld = 1'b0;
    tick;
    i_csr_wrdy = 1'b0;
    rst_n = 1'b0;
    check("rst_in_mcause", {20'd0, o_csr_waddr}, 32'h342);
    tick;
    rst_n = 1'b1;
    i_csr_wrdy = 1'b1;
    check_reset_outputs("midreset");
    for (int k = 0; k < 6; k++) tick;
    check("midreset_idle", {31'd0, o_trap_rdy}, 32'd1);
    check_drained("midreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exu_trap.md
# exu_trap

Trap-entry and trap-return sequencer in the execute stage. It consumes the exception request and mcause produced by the execute-stage exception/interrupt controller, plus mret commit requests. For each accepted event it performs the required machine-mode CSR writes (mepc, mcause, mstatus) over a single stallable CSR write port. It then flushes the pipeline and issues a PC redirect to the trap vector or to mepc.

## Interface
- No parameters. CSR addresses are fixed: mstatus 12'h300, mepc 12'h341, mcause 12'h342.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous and active-low
- i_trap_vld  in  1  trap request (controller int_ena gated by instruction valid)
- i_mcause  in  32  cause value for the request
- i_pc  in  32  PC of the trapping instruction
- i_mret  in  1  mret commit request
- o_trap_rdy  out  1  high only in IDLE; a request is accepted on any edge where o_trap_rdy=1 and (i_trap_vld|i_mret)=1
- i_mtvec  in  32  current mtvec
- i_mepc  in  32  current mepc
- i_mstatus_mie  in  1  current mstatus.MIE
- i_mstatus_mpie  in  1  current mstatus.MPIE
- o_csr_we  out  1  CSR write request
- o_csr_waddr  out  12  CSR write address
- o_csr_wdata  out  32  CSR write data
- i_csr_wrdy  in  1  CSR file accepts the write on this edge
- o_flush  out  1  pipeline flush; high in every non-IDLE state
- o_redirect_vld  out  1  PC redirect request
- o_redirect_pc  out  32  redirect target
- i_redirect_rdy  in  1  fetch accepts the redirect on this edge
- o_busy  out  1  high when state is not IDLE

## Operation
- FSM states: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, REDIR.
- On acceptance, the block latches i_mcause, {i_pc[31:1],1'b0}, i_mtvec, i_mepc, i_mstatus_mie, i_mstatus_mpie, and a kind bit (trap or mret).
- Trap transitions: IDLE → W_MEPC → W_MCAUSE → W_MSTATUS → REDIR → IDLE.
- mret transitions: IDLE → W_MSTATUS → REDIR → IDLE.
- Simultaneous i_trap_vld and i_mret: the trap is taken and the mret is discarded.
- W_* states:
  - o_csr_we=1, with address and data held stable.
  - Advance only on an edge with i_csr_wrdy=1; otherwise hold indefinitely.
- Write data:
  - mepc: the latched PC.
  - mcause: the latched cause.
  - mstatus on trap: bit 12:11 (MPP)=2'b11, bit 7 (MPIE)=latched MIE, bit 3 (MIE)=0, all other bits 0.
  - mstatus on mret: MPP=2'b11, MPIE=1, MIE=latched MPIE, all other bits 0.
- Redirect target on trap, with base={mtvec[31:2],2'b00}:
  - If mtvec[1:0]==2'b01 and cause[31]==1: base + (cause[29:0]<<2), truncated modulo 2^32 (wrap-around permitted).
  - Otherwise, including reserved modes 2'b10/2'b11: base.
- Redirect target on mret: latched mepc with bit 0 forced to 0.
- REDIR state:
  - o_redirect_vld=1, with o_redirect_pc held stable.
  - Go to IDLE on an edge with i_redirect_rdy=1.
- Inputs arriving while busy are ignored; no queueing. The upstream stage must hold its request until o_trap_rdy.

## Timing
- Reset (rst_n=0 at an edge):
  - State becomes IDLE.
  - All latched registers become 0.
  - Outputs: o_csr_we=0, o_csr_waddr=0, o_csr_wdata=0, o_flush=0, o_redirect_vld=0, o_redirect_pc=0, o_busy=0, o_trap_rdy=1.
- Reset mid-sequence abandons the sequence. No further CSR writes or redirect are issued.
- All outputs are decoded from registered state and latched data; there is no combinational path from i_* to o_*, except o_trap_rdy, which is derived from state only.
- Trap with wrdy and redirect_rdy tied high:
  - Accept at edge E0.
  - mepc write visible in cycle 1, mcause in cycle 2, mstatus in cycle 3.
  - Redirect in cycle 4.
  - o_trap_rdy high again in cycle 5.
- mret with wrdy and redirect_rdy tied high:
  - mstatus write in cycle 1, redirect in cycle 2.
  - o_trap_rdy high in cycle 3.
- Each deasserted-cycle of i_csr_wrdy or i_redirect_rdy adds exactly one cycle.
- o_flush rises in cycle 1 and falls in the first IDLE cycle.

## Test plan
- Illegal-instruction trap: mcause=0x2, pc=0x8000_0102, mtvec=0x8000_0000, MIE=1 → writes 0x341←0x8000_0102, 0x342←0x2, 0x300←0x0000_1880; redirect 0x8000_0000 in cycle 4; ready in cycle 5.
- Vectored interrupt: mtvec=0x8000_0001, mcause=0x8000_0007 → redirect 0x8000_001C. With mtvec=0xFFFF_FFF1 and cause 0x8000_0007, the target wraps to 0x0000_000C.
- mret: MPIE=1, mepc=0x8000_0205 → single write 0x300←0x0000_1888; redirect 0x8000_0204 in cycle 2; no mepc or mcause writes.
- Backpressure: i_csr_wrdy low for 3 cycles during W_MCAUSE, then i_redirect_rdy low for 2 cycles → address and data stable throughout, no duplicate writes, ready in cycle 10.
- Simultaneous trap+mret, plus a second trap while busy: trap sequence only, and the second request is accepted only when o_trap_rdy is high. Reset in W_MCAUSE → next cycle all outputs at reset values, no redirect.
